// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage
// Memory-stage load/store unit. Takes the registered memory request from the
// execute stage, runs one req/gnt/rvalid transaction on the data bus, stalls
// the pipeline (lsu_busy_o) until that transaction completes, aligns and
// extends load data, and registers the write-back payload for the WB stage.
// Non-memory and misaligned instructions pass through without a bus access.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   m_*                    memory-stage instruction (register + memory request)
//   stall_general_i        global stall: pipeline registers hold while high
//   dbus_*                 data bus. Handshake: the unit raises dbus_req_o and
//                          holds req/we/addr/be/wdata stable until a cycle in
//                          which dbus_gnt_i=1; that cycle transfers the request.
//                          For a read, exactly one later cycle with
//                          dbus_rvalid_i=1 returns dbus_rdata_i. An rvalid in
//                          the grant cycle itself is ignored.
//   lsu_busy_o             combinational stall request to the pipeline
//   w_*                    registered write-back payload
//   dbg_state              current FSM state (0 IDLE, 1 REQ, 2 RESP)
module mem_lsu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  m_regfile_waddr_i,
    input  logic [31:0] m_regfile_rd_i,
    input  logic        m_regfile_wr_i,
    input  logic        m_data_rd_i,
    input  logic        m_data_wr_i,
    input  logic [31:0] m_data_addr_i,
    input  logic [3:0]  m_data_be_i,
    input  logic        m_is_load_store_i,
    input  logic [2:0]  m_LOAD_op_i,
    input  logic        stall_general_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        lsu_busy_o,
    output logic [4:0]  w_regfile_waddr_o,
    output logic [31:0] w_regfile_wdata_o,
    output logic        w_regfile_wr_o,
    output logic        w_misaligned_o,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        done;
    logic        done_set;
    logic        access;
    logic        is_load;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        start;
    logic [4:0]  lane_shift;
    logic [31:0] rdata_sh;
    logic [31:0] ld_aligned;
    logic [31:0] ld_data;

    assign access  = m_is_load_store_i & (m_data_rd_i | m_data_wr_i);
    assign is_load = access & m_data_rd_i;

    // Access size comes from the load op for loads and from the enables for
    // stores; either source marking it as halfword/word is enough.
    assign is_half = (m_data_rd_i & ((m_LOAD_op_i == 3'b001) | (m_LOAD_op_i == 3'b101)))
                   | (m_data_be_i == 4'b0011);
    assign is_word = (m_data_rd_i & (m_LOAD_op_i == 3'b010))
                   | (m_data_be_i == 4'b1111);

    assign misaligned = access & ((is_half & m_data_addr_i[0])
                                | (is_word & (m_data_addr_i[1:0] != 2'b00)));

    // done blocks reissue of an instruction that is still held in this stage.
    assign start = access & ~misaligned & ~done;

    assign lane_shift   = {m_data_addr_i[1:0], 3'b000};
    assign dbus_addr_o  = {m_data_addr_i[31:2], 2'b00};
    assign dbus_be_o    = m_data_be_i << m_data_addr_i[1:0];
    assign dbus_wdata_o = m_regfile_rd_i << lane_shift;
    assign dbus_we_o    = m_data_wr_i;

    assign lsu_busy_o = (state != IDLE) | start;
    assign dbg_state  = state;

    // Load alignment
    assign rdata_sh = dbus_rdata_i >> lane_shift;

    always_comb begin
        ld_aligned = 32'h0;
        case (m_LOAD_op_i)
            3'b000:  ld_aligned = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  ld_aligned = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b010:  ld_aligned = dbus_rdata_i;
            3'b100:  ld_aligned = {24'h0, rdata_sh[7:0]};
            3'b101:  ld_aligned = {16'h0, rdata_sh[15:0]};
            default: ld_aligned = 32'h0;
        endcase
    end

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        done_set   = 1'b0;
        dbus_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                dbus_req_o = 1'b1;
                if (dbus_gnt_i) begin
                    if (m_data_rd_i) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = IDLE;
                        done_set  = 1'b1;
                    end
                end
            end
            RESP: begin
                if (dbus_rvalid_i) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                done <= 1'b0;
        else if (done_set)         done <= 1'b1;
        else if (!stall_general_i) done <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              ld_data <= 32'h0;
        else if (state == RESP && dbus_rvalid_i) ld_data <= ld_aligned;
    end

    // Write-back register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_regfile_waddr_o <= 5'd0;
            w_regfile_wdata_o <= 32'h0;
            w_regfile_wr_o    <= 1'b0;
            w_misaligned_o    <= 1'b0;
        end else if (!stall_general_i) begin
            w_regfile_waddr_o <= m_regfile_waddr_i;
            w_regfile_wdata_o <= is_load ? ld_data : m_regfile_rd_i;
            w_regfile_wr_o    <= m_regfile_wr_i & ~(misaligned & m_data_rd_i);
            w_misaligned_o    <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed testbench for mem_lsu_stage. The pipeline stall is modelled as
// lsu_busy_o OR an externally held stall (ext_stall).
module tb_mem_lsu_stage;

    logic        clk;
    logic        rst_n;
    logic [4:0]  m_regfile_waddr_i;
    logic [31:0] m_regfile_rd_i;
    logic        m_regfile_wr_i;
    logic        m_data_rd_i;
    logic        m_data_wr_i;
    logic [31:0] m_data_addr_i;
    logic [3:0]  m_data_be_i;
    logic        m_is_load_store_i;
    logic [2:0]  m_LOAD_op_i;
    logic        stall_general_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        lsu_busy_o;
    logic [4:0]  w_regfile_waddr_o;
    logic [31:0] w_regfile_wdata_o;
    logic        w_regfile_wr_o;
    logic        w_misaligned_o;
    logic [1:0]  dbg_state;

    logic        ext_stall;
    int          n_checks;
    int          n_pass;
    int          n_gnt;
    logic [31:0] exp_q[$];

    mem_lsu_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .m_regfile_waddr_i (m_regfile_waddr_i),
        .m_regfile_rd_i    (m_regfile_rd_i),
        .m_regfile_wr_i    (m_regfile_wr_i),
        .m_data_rd_i       (m_data_rd_i),
        .m_data_wr_i       (m_data_wr_i),
        .m_data_addr_i     (m_data_addr_i),
        .m_data_be_i       (m_data_be_i),
        .m_is_load_store_i (m_is_load_store_i),
        .m_LOAD_op_i       (m_LOAD_op_i),
        .stall_general_i   (stall_general_i),
        .dbus_req_o        (dbus_req_o),
        .dbus_we_o         (dbus_we_o),
        .dbus_addr_o       (dbus_addr_o),
        .dbus_be_o         (dbus_be_o),
        .dbus_wdata_o      (dbus_wdata_o),
        .dbus_gnt_i        (dbus_gnt_i),
        .dbus_rvalid_i     (dbus_rvalid_i),
        .dbus_rdata_i      (dbus_rdata_i),
        .lsu_busy_o        (lsu_busy_o),
        .w_regfile_waddr_o (w_regfile_waddr_o),
        .w_regfile_wdata_o (w_regfile_wdata_o),
        .w_regfile_wr_o    (w_regfile_wr_o),
        .w_misaligned_o    (w_misaligned_o),
        .dbg_state         (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign stall_general_i = lsu_busy_o | ext_stall;

    // Count granted transactions
    initial n_gnt = 0;
    always @(posedge clk) begin
        if (rst_n && dbus_req_o && dbus_gnt_i) n_gnt = n_gnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic nop();
        m_is_load_store_i = 1'b0;
        m_data_rd_i       = 1'b0;
        m_data_wr_i       = 1'b0;
        m_data_addr_i     = 32'h0;
        m_data_be_i       = 4'h0;
        m_LOAD_op_i       = 3'b000;
        m_regfile_rd_i    = 32'h0;
        m_regfile_waddr_i = 5'd0;
        m_regfile_wr_i    = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic [31:0] addr, input logic [3:0] be,
                         input logic [2:0] op, input logic [31:0] rdv,
                         input logic [4:0] waddr, input logic rwr);
        m_is_load_store_i = 1'b1;
        m_data_rd_i       = ld;
        m_data_wr_i       = ~ld;
        m_data_addr_i     = addr;
        m_data_be_i       = be;
        m_LOAD_op_i       = op;
        m_regfile_rd_i    = rdv;
        m_regfile_waddr_i = waddr;
        m_regfile_wr_i    = rwr;
    endtask

    // Called at a negedge. Runs one aligned access with gnt after gnt_dly
    // extra REQ cycles and rvalid one cycle after gnt; returns at the negedge
    // after the write-back edge.
    task automatic issue(input string tag, input logic ld, input logic [31:0] addr,
                         input logic [3:0] be, input logic [2:0] op, input logic [31:0] rdv,
                         input logic [4:0] waddr, input logic rwr, input int gnt_dly,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata);
        int g0;
        drive(ld, addr, be, op, rdv, waddr, rwr);
        #1;
        check({tag, "_c0_busy"}, {31'h0, lsu_busy_o}, 32'h1);
        check({tag, "_c0_req"}, {31'h0, dbus_req_o}, 32'h0);
        g0 = n_gnt;
        @(negedge clk);
        for (int i = 0; i <= gnt_dly; i++) begin
            check({tag, "_req"}, {31'h0, dbus_req_o}, 32'h1);
            check({tag, "_addr"}, dbus_addr_o, {addr[31:2], 2'b00});
            check({tag, "_be"}, {28'h0, dbus_be_o}, {28'h0, exp_be});
            check({tag, "_we"}, {31'h0, dbus_we_o}, {31'h0, ~ld});
            check({tag, "_wdata"}, dbus_wdata_o, exp_wdata);
            check({tag, "_busy"}, {31'h0, lsu_busy_o}, 32'h1);
            dbus_gnt_i = (i == gnt_dly);
            @(negedge clk);
        end
        dbus_gnt_i = 1'b0;
        if (ld) begin
            check({tag, "_resp_req"}, {31'h0, dbus_req_o}, 32'h0);
            check({tag, "_resp_busy"}, {31'h0, lsu_busy_o}, 32'h1);
            dbus_rvalid_i = 1'b1;
            dbus_rdata_i  = rdata;
            @(negedge clk);
            dbus_rvalid_i = 1'b0;
            dbus_rdata_i  = 32'h0;
        end
        #1;
        check({tag, "_done_busy"}, {31'h0, lsu_busy_o}, 32'h0);
        check({tag, "_done_req"}, {31'h0, dbus_req_o}, 32'h0);
        check({tag, "_ngnt"}, n_gnt - g0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_wb(input string tag, input logic [4:0] waddr, input logic wr,
                            input logic mis);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        check({tag, "_w_wdata"}, w_regfile_wdata_o, exp);
        check({tag, "_w_waddr"}, {27'h0, w_regfile_waddr_o}, {27'h0, waddr});
        check({tag, "_w_wr"}, {31'h0, w_regfile_wr_o}, {31'h0, wr});
        check({tag, "_w_mis"}, {31'h0, w_misaligned_o}, {31'h0, mis});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'h0, dbus_req_o}, 32'h0);
        check({tag, "_state"}, {30'h0, dbg_state}, 32'h0);
        check({tag, "_w_waddr"}, {27'h0, w_regfile_waddr_o}, 32'h0);
        check({tag, "_w_wdata"}, w_regfile_wdata_o, 32'h0);
        check({tag, "_w_wr"}, {31'h0, w_regfile_wr_o}, 32'h0);
        check({tag, "_w_mis"}, {31'h0, w_misaligned_o}, 32'h0);
    endtask

    initial begin
        int g0;
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        ext_stall     = 1'b0;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'h0;
        nop();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_busy", {31'h0, lsu_busy_o}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW at 0x100
        issue("lw", 1'b1, 32'h100, 4'hf, 3'b010, 32'h0, 5'd5, 1'b1, 0, 32'hDEADBEEF, 4'hf, 32'h0);
        exp_q.push_back(32'hDEADBEEF);
        check_wb("lw", 5'd5, 1'b1, 1'b0);

        // LB / LBU at 0x203 (byte lane 3)
        issue("lb", 1'b1, 32'h203, 4'h1, 3'b000, 32'h0, 5'd6, 1'b1, 0, 32'h80FFFFFF, 4'h8, 32'h0);
        exp_q.push_back(32'hFFFFFF80);
        check_wb("lb", 5'd6, 1'b1, 1'b0);
        issue("lbu", 1'b1, 32'h203, 4'h1, 3'b100, 32'h0, 5'd6, 1'b1, 0, 32'h80FFFFFF, 4'h8, 32'h0);
        exp_q.push_back(32'h00000080);
        check_wb("lbu", 5'd6, 1'b1, 1'b0);

        // LH / LHU at 0x002 (upper halfword)
        issue("lh", 1'b1, 32'h002, 4'h3, 3'b001, 32'h0, 5'd8, 1'b1, 1, 32'h80011234, 4'hc, 32'h0);
        exp_q.push_back(32'hFFFF8001);
        check_wb("lh", 5'd8, 1'b1, 1'b0);
        issue("lhu", 1'b1, 32'h002, 4'h3, 3'b101, 32'h0, 5'd8, 1'b1, 0, 32'h80011234, 4'hc, 32'h0);
        exp_q.push_back(32'h00008001);
        check_wb("lhu", 5'd8, 1'b1, 1'b0);

        // SH at 0x302
        issue("sh", 1'b0, 32'h302, 4'h3, 3'b000, 32'h0000BEEF, 5'd0, 1'b0, 0, 32'h0, 4'hc, 32'hBEEF0000);
        exp_q.push_back(32'h0000BEEF);
        check_wb("sh", 5'd0, 1'b0, 1'b0);

        // SW with gnt delayed 3 cycles
        issue("sw", 1'b0, 32'h400, 4'hf, 3'b000, 32'h12345678, 5'd3, 1'b0, 3, 32'h0, 4'hf, 32'h12345678);
        exp_q.push_back(32'h12345678);
        check_wb("sw", 5'd3, 1'b0, 1'b0);

        // Misaligned LW at 0x102: no bus access, zero latency, wdata is the
        // last captured load (LHU result)
        g0 = n_gnt;
        drive(1'b1, 32'h102, 4'hf, 3'b010, 32'h0, 5'd9, 1'b1);
        #1;
        check("mis_busy", {31'h0, lsu_busy_o}, 32'h0);
        check("mis_req", {31'h0, dbus_req_o}, 32'h0);
        @(negedge clk);
        exp_q.push_back(32'h00008001);
        check_wb("mis", 5'd9, 1'b0, 1'b1);
        check("mis_ngnt", n_gnt - g0, 32'd0);

        // Reset while in RESP, then the held LW is reissued once
        drive(1'b1, 32'h500, 4'hf, 3'b010, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        dbus_gnt_i = 1'b0;
        check("rresp_state", {30'h0, dbg_state}, 32'h2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rresp");
        @(negedge clk);
        rst_n = 1'b1;
        issue("rlw", 1'b1, 32'h500, 4'hf, 3'b010, 32'h0, 5'd7, 1'b1, 0, 32'h0BADF00D, 4'hf, 32'h0);
        exp_q.push_back(32'h0BADF00D);
        check_wb("rlw", 5'd7, 1'b1, 1'b0);

        // LW completes under an external stall held 5 cycles: no reissue,
        // write-back holds the previous instruction's values
        ext_stall = 1'b1;
        issue("stl", 1'b1, 32'h600, 4'hf, 3'b010, 32'h0, 5'd10, 1'b1, 0, 32'hCAFEF00D, 4'hf, 32'h0);
        g0 = n_gnt;
        for (int i = 0; i < 5; i++) begin
            check("stl_hold_req", {31'h0, dbus_req_o}, 32'h0);
            check("stl_hold_wdata", w_regfile_wdata_o, 32'h0BADF00D);
            check("stl_hold_waddr", {27'h0, w_regfile_waddr_o}, 32'd7);
            @(negedge clk);
        end
        check("stl_ngnt", n_gnt - g0, 32'd0);
        ext_stall = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'hCAFEF00D);
        check_wb("stl", 5'd10, 1'b1, 1'b0);

        nop();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
